// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related selectors.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone
    } state_e;

    localparam int unsigned DATA_W_DEF = 8;

    // A single requester still needs one index bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_done;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      arb_busy;
    logic [idx_w(NUM_REQ)-1:0] owner;
    logic                      err_timeout;

    // Arbiter side: drives the transmitter start handshake and the client acks.
    modport master (
        input  req, req_data, tx_busy,
        output req_ack, req_done, tx_start, tx_data, arb_busy, owner, err_timeout
    );

    // Environment side: clients plus the transmitter instance.
    modport slave (
        output req, req_data, tx_busy,
        input  req_ack, req_done, tx_start, tx_data, arb_busy, owner, err_timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [idx_w(NUM_REQ)-1:0] ptr,
    output logic                      valid,
    output logic [idx_w(NUM_REQ)-1:0] idx
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    logic [IW:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            // ptr + i stays below 2*NUM_REQ, so one conditional subtract wraps it.
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(NUM_REQ)) begin
                cand = cand - (IW + 1)'(NUM_REQ);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional start-timeout supervision is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic             clk,
    input logic             reset,
    uart_tx_arbiter_if.master bus
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYC nonzero");
    end

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_prev_q;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        ack_d   = '0;
        done_d  = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d          = pick_idx;
                    data_d           = bus.req_data[pick_idx * DATA_W +: DATA_W];
                    ack_d[pick_idx]  = 1'b1;
                    ptr_d            = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d          = StStart;
                end
            end
            StStart: begin
                // Only a fresh rise counts; a level left over from earlier use does not.
                if (bus.tx_busy && !busy_prev_q) begin
                    state_d = StWaitDone;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // Tracks the line even through reset so a busy level seen on START entry is not a rise.
    always_ff @(posedge clk) begin
        busy_prev_q <= bus.tx_busy;
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.req_ack  = ack_q;
    assign bus.req_done = done_q;
    assign bus.tx_start = (state_q == StStart);
    assign bus.tx_data  = data_q;
    assign bus.arb_busy = (state_q != StIdle);
    assign bus.owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a loopback transmitter model.
module tb_uart_tx_arbiter;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         done;
    } exp_t;

    logic clk;
    logic reset;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .DATA_W     (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t       exp_ack_q[$];
    exp_t       exp_done_q[$];
    logic [7:0] line_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ack_count = 0;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    bit   tx_en = 1'b1;
    int   model_cnt = 0;
    int   frame_len = 10;

    assign bus.tx_busy = model_busy | force_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected/expired event, required none", name);
    endtask

    function automatic exp_t mk(input int idx, input logic [7:0] data, input bit done);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.done = done;
        return e;
    endfunction

    // Loopback transmitter: busy one cycle after tx_start, for frame_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) model_busy = 1'b0;
            end else if (tx_en && !force_busy && bus.tx_start) begin
                model_busy = 1'b1;
                model_cnt  = frame_len;
                line_q.push_back(bus.tx_data);
            end
        end
    end

    // Monitor: pops expectations on every ack and done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.req_ack != 4'b0) begin
            if (exp_ack_q.size() == 0) begin
                flag("ack_unexpected");
            end else begin
                e = exp_ack_q.pop_front();
                check("ack_onehot", {28'b0, bus.req_ack}, 32'(1) << e.idx);
                check("ack_owner", {30'b0, bus.owner}, e.idx);
                check("ack_tx_data", {24'b0, bus.tx_data}, {24'b0, e.data});
                ack_count++;
                if (e.done) exp_done_q.push_back(e);
            end
        end
        if (!reset && bus.req_done != 4'b0) begin
            if (exp_done_q.size() == 0) begin
                flag("done_unexpected");
            end else begin
                e = exp_done_q.pop_front();
                check("done_onehot", {28'b0, bus.req_done}, 32'(1) << e.idx);
                check("done_tx_data", {24'b0, bus.tx_data}, {24'b0, e.data});
                if (line_q.size() == 0) flag("line_empty");
                else check("line_byte", {24'b0, line_q.pop_front()}, {24'b0, e.data});
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ctrl", {27'b0, bus.tx_start, bus.req_ack, bus.req_done, bus.err_timeout,
                           bus.arb_busy}, 32'h0);
        check("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
        check("rst_owner", {30'b0, bus.owner}, 32'h0);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        exp_ack_q.delete();
        exp_done_q.delete();
        line_q.delete();
        repeat (cycles) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (ack_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ack_count < target) flag("ack_wait");
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_ack_q.size() != 0 || exp_done_q.size() != 0 || bus.arb_busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_ack_q.size() != 0 || exp_done_q.size() != 0 || bus.arb_busy) flag("drain");
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Single requester 0: one-cycle latency to ack, tx_start high alongside.
        exp_ack_q.push_back(mk(0, 8'hF0, 1'b1));
        bus.req_data[0 +: 8] = 8'hF0;
        bus.req = 4'b0001;
        @(negedge clk);
        check("t1_ack", {28'b0, bus.req_ack}, 32'h1);
        check("t1_tx_start", {31'b0, bus.tx_start}, 32'h1);
        #1;
        bus.req = 4'b0000;
        drain(100);

        // All four held from pointer 0: grants 0,1,2,3,0.
        apply_reset(2);
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 5; i++) exp_ack_q.push_back(mk(i % 4, 8'hA0 + 8'(i % 4), 1'b1));
        bus.req = 4'b1111;
        wait_acks(ack_count + 5, 200);
        bus.req = 4'b0000;
        drain(100);

        // Pointer now 1; grant 2 alone moves it to 3, then {2,3} -> 3 then 2.
        exp_ack_q.push_back(mk(2, 8'h22, 1'b1));
        bus.req_data[16 +: 8] = 8'h22;
        bus.req = 4'b0100;
        wait_acks(ack_count + 1, 50);
        bus.req = 4'b0000;
        drain(100);
        exp_ack_q.push_back(mk(3, 8'h33, 1'b1));
        exp_ack_q.push_back(mk(2, 8'h32, 1'b1));
        bus.req_data[24 +: 8] = 8'h33;
        bus.req_data[16 +: 8] = 8'h32;
        bus.req = 4'b1100;
        wait_acks(ack_count + 2, 100);
        bus.req = 4'b0000;
        drain(100);
        // Pointer must be back at 3: {0,3} serves 3 first.
        exp_ack_q.push_back(mk(3, 8'h3F, 1'b1));
        exp_ack_q.push_back(mk(0, 8'h30, 1'b1));
        bus.req_data[24 +: 8] = 8'h3F;
        bus.req_data[0 +: 8]  = 8'h30;
        bus.req = 4'b1001;
        wait_acks(ack_count + 2, 100);
        bus.req = 4'b0000;
        drain(100);

        // Busy already high before the grant: tx_start must hold until a fresh rise.
        @(negedge clk);
        force_busy = 1'b1;
        exp_ack_q.push_back(mk(1, 8'h55, 1'b1));
        bus.req_data[8 +: 8] = 8'h55;
        bus.req = 4'b0010;
        wait_acks(ack_count + 1, 50);
        bus.req = 4'b0000;
        repeat (5) @(negedge clk);
        check("busy_hold_tx_start", {31'b0, bus.tx_start}, 32'h1);
        check("busy_hold_arb_busy", {31'b0, bus.arb_busy}, 32'h1);
        force_busy = 1'b0;
        drain(100);

        // Reset 300 cycles into a long frame; the abandoned byte gets no done.
        frame_len = 400;
        exp_ack_q.push_back(mk(0, 8'hF0, 1'b1));
        bus.req_data[0 +: 8] = 8'hF0;
        bus.req = 4'b0001;
        wait_acks(ack_count + 1, 50);
        bus.req = 4'b0000;
        repeat (300) @(negedge clk);
        apply_reset(200);
        frame_len = 10;
        exp_ack_q.push_back(mk(1, 8'hDD, 1'b1));
        bus.req_data[8 +: 8] = 8'hDD;
        bus.req = 4'b0010;
        wait_acks(ack_count + 1, 50);
        bus.req = 4'b0000;
        drain(100);

`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int n = 0;
            apply_reset(2);
            tx_en = 1'b0;
            exp_ack_q.push_back(mk(0, 8'h77, 1'b0));
            bus.req_data[0 +: 8] = 8'h77;
            bus.req = 4'b0001;
            @(negedge clk);
            check("to_ack", {28'b0, bus.req_ack}, 32'h1);
            #1;
            bus.req = 4'b0000;
            while (!bus.err_timeout && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("to_latency", n, 16);
            check("to_idle", {30'b0, bus.tx_start, bus.arb_busy}, 32'h0);
            tx_en = 1'b1;
            drain(50);
        end
`endif

        repeat (5) @(negedge clk);
        check("end_queues", exp_ack_q.size() + exp_done_q.size(), 0);
        check("end_line", line_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (tx_start / tx_data / tx_busy handshake) among NUM_REQ byte producers.
- Round-robin arbitration, one byte per grant.
- Latches the winner's byte, drives the start handshake, holds data stable until the transmitter frees, then reports completion to the owner.
- Sits between client logic and the transmit instance inside the UART top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, byte width; matches transmitter tx_data.
- TIMEOUT_CYC, 1024, max cycles to wait for tx_busy to rise after tx_start (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held with data until matching req_ack.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  output  NUM_REQ  one-hot, 1-cycle pulse: byte latched, requester may change data/drop req.
- req_done  output  NUM_REQ  one-hot, 1-cycle pulse: owner's byte finished on the line.
- tx_start  output  1  start request to transmitter.
- tx_data  output  DATA_W  byte to transmitter.
- tx_busy  input  1  transmitter busy flag.
- arb_busy  output  1  high whenever state != IDLE.
- owner  output  $clog2(NUM_REQ)  index of current/last granted requester.
- err_timeout  output  1  1-cycle pulse on start timeout (0 without the optional feature).

Behaviour:
- Reset (synchronous) values:
  - State = IDLE; rr pointer = 0; owner = 0.
  - tx_start = 0; tx_data = 0; req_ack = 0; req_done = 0; err_timeout = 0; arb_busy = 0.
- Reset mid-operation: an in-flight byte is abandoned and gets no req_done. The transmitter is not aborted by this block.
- IDLE:
  - If any req bit is set, pick the first set bit searching from the rr pointer upward with wrap (pointer, pointer+1, ... NUM_REQ-1, 0, ...).
  - Same edge: latch req_data slice into tx_data, set owner, pulse req_ack[owner], go START.
  - rr pointer = (owner+1) mod NUM_REQ.
- START:
  - tx_start = 1, held high until tx_busy sampled 1.
  - On that edge: tx_start = 0, go WAIT_DONE.
  - If tx_busy is already 1 on entry, the transmitter is still busy from outside use. Keep tx_start high; transition only on a 0->1 edge of tx_busy (track the previous-cycle value).
- WAIT_DONE:
  - tx_data held stable.
  - When tx_busy sampled 0: pulse req_done[owner], go IDLE.
  - Earliest next req_ack is the following cycle (no back-to-back grant on the same edge).
- Latency: req high in IDLE -> req_ack on the next edge -> tx_start in that same cycle onward.
- Fairness:
  - A requester holding req continuously waits at most NUM_REQ-1 other bytes.
  - A requester whose req falls before being granted is skipped. No ack is issued and no error is raised.
- req/req_data changes while not acked are sampled only in IDLE; changes in other states are ignored.
- Simultaneous requests: resolved purely by the rr pointer.
- Single requester: granted repeatedly, one byte per IDLE visit.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in START.
  - If tx_busy has not risen after TIMEOUT_CYC cycles: tx_start = 0, pulse err_timeout, no req_done, go IDLE.
  - The rr pointer stays already advanced.
- Undefined:
  - START waits indefinitely.
  - err_timeout is tied 0; no counter is synthesized.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, WAIT_DONE}.
  - DATA_W default constant.
  - Helper function for the round-robin index width.
- Sub-module rr_pick: combinational round-robin selector with inputs req and pointer, outputs a valid flag and the index. It is reusable for RX-side fan-out.

Test Plan:
- Single req[0] with 0xF0, loopback transmitter -> one req_ack[0]; tx_start high until tx_busy=1; tx_data=0xF0 throughout; req_done[0] when busy falls.
- req=4'b1111 with bytes 0xA0..0xA3 held -> grant order 0,1,2,3,0; line carries 0xA0,0xA1,0xA2,0xA3.
- req[2] and req[3] both high, pointer=3 -> requester 3 served first, then 2; pointer afterwards = 3.
- reset asserted 3000 ns into a 0xF0 transfer for 2000 ns, then req[1]=0xDD -> all outputs at reset values during reset; no req_done[0]; 0xDD transmitted with owner=1.
- tx_busy forced 1 before a grant -> tx_start stays high; no WAIT_DONE until tx_busy falls and rises again.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, tx_busy stuck 0 -> err_timeout pulse 16 cycles after tx_start rises; back to IDLE; no req_done.
